// File: rtl/scm_wr_packer_32to64.sv
// scm_wr_packer_32to64
// Write-side gather stage for a latch-SCM buffer. Pairs consecutive 32-bit
// input beats into 64-bit rows (first beat -> [31:0], second -> [63:32]) and
// issues one-cycle row writes at an auto-incrementing address that starts at
// a programmable base and wraps modulo N_ROWS.
//
// Build option:
//   SCM_WR_PACKER_FLUSH_PAD_EN  when defined, an odd-length packet's last beat
//                               is written as {zero, lo}; when undefined it is
//                               dropped and only complete pairs are stored.
//
// State table:
//   IDLE  | not started (or packet finished); input not accepted
//   LO    | waiting for the low half of a row
//   HI    | low half held, waiting for the high half
//   FLUSH | packet ended on a low half; pad-write or drop it
//   DRAIN | packet ended; wait for the last write to commit, then pulse done
//   FULL  | all N_ROWS rows committed; only start_i leaves this state

module scm_wr_packer_32to64 #(
  parameter int WADDR_WIDTH = 5,
  parameter int IN_WIDTH    = 32,
  parameter int OUT_WIDTH   = 64,
  parameter int N_ROWS      = 2**WADDR_WIDTH
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   start_i,
  input  logic [WADDR_WIDTH-1:0] base_addr_i,
  input  logic                   in_valid_i,
  output logic                   in_ready_o,
  input  logic [IN_WIDTH-1:0]    in_data_i,
  input  logic                   in_last_i,
  input  logic                   wr_stall_i,
  output logic                   WriteEnable_o,
  output logic [WADDR_WIDTH-1:0] WriteAddr_o,
  output logic [OUT_WIDTH-1:0]   WriteData_o,
  output logic [WADDR_WIDTH:0]   word_cnt_o,
  output logic                   full_o,
  output logic                   done_o
);

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_LO    = 3'd1,
    ST_HI    = 3'd2,
    ST_FLUSH = 3'd3,
    ST_DRAIN = 3'd4,
    ST_FULL  = 3'd5
  } state_t;

  localparam logic [WADDR_WIDTH:0]   CNT_FULL  = (WADDR_WIDTH+1)'(N_ROWS);
  localparam logic [WADDR_WIDTH-1:0] ADDR_LAST = WADDR_WIDTH'(N_ROWS - 1);

  state_t                 state_q;
  logic [WADDR_WIDTH-1:0] addr_q;
  logic [IN_WIDTH-1:0]    lo_q;
  logic                   we_q;
  logic [WADDR_WIDTH-1:0] waddr_q;
  logic [OUT_WIDTH-1:0]   wdata_q;
  logic [WADDR_WIDTH:0]   cnt_q;
  logic                   full_q;
  logic                   done_q;

  logic                   wr_hold;
  logic                   commit;
  logic                   accept;
  logic                   fill;
  logic [WADDR_WIDTH-1:0] addr_inc;
  logic [WADDR_WIDTH-1:0] addr_cur;

  // Handshake, commit and address-advance terms shared by the FSM.
  always_comb begin
    wr_hold    = we_q && wr_stall_i;
    commit     = we_q && !wr_stall_i;
    in_ready_o = ((state_q == ST_LO) || (state_q == ST_HI)) && !full_q
                 && !wr_hold && !start_i;
    accept     = in_valid_i && in_ready_o;
    // The commit that brings the count to N_ROWS.
    fill       = commit && (cnt_q == (CNT_FULL - 1'b1));
    addr_inc   = (addr_q == ADDR_LAST) ? '0 : addr_q + 1'b1;
    // Address a write issued this cycle lands on, after any same-cycle commit.
    addr_cur   = commit ? addr_inc : addr_q;
  end

  // Packing FSM with registered write port, counters and done pulse.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      addr_q  <= '0;
      lo_q    <= '0;
      we_q    <= 1'b0;
      waddr_q <= '0;
      wdata_q <= '0;
      cnt_q   <= '0;
      full_q  <= 1'b0;
      done_q  <= 1'b0;
    end else if (start_i) begin
      // Restart wins over everything, including a stalled pending write.
      state_q <= ST_LO;
      addr_q  <= base_addr_i;
      lo_q    <= '0;
      we_q    <= 1'b0;
      cnt_q   <= '0;
      full_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;

      if (commit) begin
        addr_q <= addr_inc;
        cnt_q  <= cnt_q + 1'b1;
        we_q   <= 1'b0;
      end

      if (fill) begin
        // Buffer is now full: discard any held low half. A packet that ends
        // on this commit (or whose last beat arrives with it) still reports
        // completion.
        state_q <= ST_FULL;
        full_q  <= 1'b1;
        lo_q    <= '0;
        done_q  <= (state_q == ST_DRAIN) || (accept && in_last_i);
      end else begin
        unique case (state_q)
          ST_IDLE, ST_FULL: begin
          end

          ST_LO: begin
            if (accept) begin
              lo_q    <= in_data_i;
              state_q <= in_last_i ? ST_FLUSH : ST_HI;
            end
          end

          ST_HI: begin
            if (accept) begin
              we_q    <= 1'b1;
              waddr_q <= addr_cur;
              wdata_q <= {in_data_i, lo_q};
              state_q <= in_last_i ? ST_DRAIN : ST_LO;
            end
          end

          ST_FLUSH: begin
`ifdef SCM_WR_PACKER_FLUSH_PAD_EN
            // Store the odd beat as a zero-padded row; DRAIN waits for it.
            we_q    <= 1'b1;
            waddr_q <= addr_cur;
            wdata_q <= {{(OUT_WIDTH-IN_WIDTH){1'b0}}, lo_q};
            state_q <= ST_DRAIN;
`else
            // Drop the odd beat. Nothing can be pending here (the beat that
            // brought us here was only accepted with no stalled write), so
            // the drain step is folded in and done pulses next cycle.
            lo_q    <= '0;
            done_q  <= 1'b1;
            state_q <= ST_IDLE;
`endif
          end

          ST_DRAIN: begin
            if (!we_q || commit) begin
              done_q  <= 1'b1;
              state_q <= ST_IDLE;
            end
          end

          default: state_q <= ST_IDLE;
        endcase
      end
    end
  end

  assign WriteEnable_o = we_q;
  assign WriteAddr_o   = waddr_q;
  assign WriteData_o   = wdata_q;
  assign word_cnt_o    = cnt_q;
  assign full_o        = full_q;
  assign done_o        = done_q;

endmodule

// File: tb/tb_scm_wr_packer_32to64.sv
module tb_scm_wr_packer_32to64;

  localparam int AW = 5;
  localparam int NR = 32;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start_i = 1'b0;
  logic [AW-1:0] base_addr_i = '0;
  logic          in_valid_i = 1'b0;
  logic          in_ready_o;
  logic [31:0]   in_data_i = '0;
  logic          in_last_i = 1'b0;
  logic          wr_stall_i = 1'b0;
  logic          WriteEnable_o;
  logic [AW-1:0] WriteAddr_o;
  logic [63:0]   WriteData_o;
  logic [AW:0]   word_cnt_o;
  logic          full_o;
  logic          done_o;

  int checks = 0;
  int failures = 0;
  int done_cnt = 0;
  int beat_ticks = 0;

  logic [31:0] beats_q[$];
  logic [68:0] exp_q[$];
  logic [68:0] got_q[$];

  always #5 clk = ~clk;

  scm_wr_packer_32to64 dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .start_i      (start_i),
    .base_addr_i  (base_addr_i),
    .in_valid_i   (in_valid_i),
    .in_ready_o   (in_ready_o),
    .in_data_i    (in_data_i),
    .in_last_i    (in_last_i),
    .wr_stall_i   (wr_stall_i),
    .WriteEnable_o(WriteEnable_o),
    .WriteAddr_o  (WriteAddr_o),
    .WriteData_o  (WriteData_o),
    .word_cnt_o   (word_cnt_o),
    .full_o       (full_o),
    .done_o       (done_o)
  );

  // Reference: rows = consecutive beat pairs at base, base+1, ... mod NR;
  // an odd trailing beat becomes a zero-padded row only with the pad option;
  // at most NR rows are ever stored.
  function automatic void model_packet(input int base, input int n);
    exp_q.delete();
    for (int k = 0; 2*k + 1 < n; k++)
      exp_q.push_back({5'((base + k) % NR), beats_q[2*k+1], beats_q[2*k]});
`ifdef SCM_WR_PACKER_FLUSH_PAD_EN
    if ((n % 2) == 1)
      exp_q.push_back({5'((base + n/2) % NR), 32'h0, beats_q[n-1]});
`endif
    while (exp_q.size() > NR) void'(exp_q.pop_back());
  endfunction

  // One clock cycle: called just after a negedge with inputs set; samples
  // the handshake, commits and done at negedge+1, returns at the next negedge.
  task automatic tick(output bit acc);
    #1;
    acc = in_valid_i && in_ready_o;
    if (WriteEnable_o && !wr_stall_i) got_q.push_back({WriteAddr_o, WriteData_o});
    if (done_o) done_cnt++;
    @(negedge clk);
  endtask

  task automatic run_packet(input int base, input int gap_pct, input int stall_pct);
    bit acc;
    int n;
    int guard;
    n = beats_q.size();
    got_q.delete();
    done_cnt = 0;
    beat_ticks = 0;
    start_i = 1'b1; base_addr_i = AW'(base); in_valid_i = 1'b0; wr_stall_i = 1'b0;
    tick(acc);
    start_i = 1'b0;
    for (int i = 0; i < n; i++) begin
      guard = 0;
      do begin
        in_valid_i = (int'($urandom_range(99)) >= gap_pct);
        in_data_i  = in_valid_i ? beats_q[i] : $urandom;
        in_last_i  = (i == n - 1);
        wr_stall_i = (int'($urandom_range(99)) < stall_pct);
        tick(acc);
        guard++;
        beat_ticks++;
      end while (!acc && guard < 300);
      if (!acc) begin
        checks++; failures++;
        $display("FAIL beat_accept_timeout beat=%0d accepted=0 expected=1", i);
        in_valid_i = 1'b0; in_last_i = 1'b0; wr_stall_i = 1'b0;
        return;
      end
    end
    in_valid_i = 1'b0; in_last_i = 1'b0;
    guard = 0;
    while (done_cnt == 0 && guard < 100) begin
      wr_stall_i = (guard < 4) && (int'($urandom_range(99)) < stall_pct);
      tick(acc);
      guard++;
    end
    wr_stall_i = 1'b0;
    checks++;
    if (done_cnt == 0) begin
      failures++;
      $display("FAIL done_timeout done_seen=0 expected=1");
    end
    repeat (3) tick(acc);
    model_packet(base, n);
  endtask

  task automatic test_reset();
    bit acc;
    checks++;
    if ({WriteEnable_o, WriteAddr_o, WriteData_o, word_cnt_o, full_o, done_o, in_ready_o} !== '0) begin
      failures++;
      $display("FAIL reset_outputs we=%0b addr=%0d data=%h cnt=%0d full=%0b done=%0b rdy=%0b expected all 0",
               WriteEnable_o, WriteAddr_o, WriteData_o, word_cnt_o, full_o, done_o, in_ready_o);
    end
    rst_n = 1'b1;
    in_valid_i = 1'b1; in_data_i = 32'hdead_beef;
    repeat (3) begin
      tick(acc);
      checks++;
      if (acc !== 1'b0) begin
        failures++;
        $display("FAIL idle_no_accept accepted=%0b expected=0", acc);
      end
    end
    in_valid_i = 1'b0;
    checks++;
    if ({WriteEnable_o, word_cnt_o, done_o} !== '0) begin
      failures++;
      $display("FAIL idle_quiet we=%0b cnt=%0d done=%0b expected 0", WriteEnable_o, word_cnt_o, done_o);
    end
  endtask

  task automatic test_basic_pairing();
    bit acc;
    got_q.delete(); done_cnt = 0;
    start_i = 1'b1; base_addr_i = 5'd3; tick(acc); start_i = 1'b0;
    in_valid_i = 1'b1; in_data_i = 32'h1111_1111; in_last_i = 1'b0; tick(acc);
    checks++;
    if (acc !== 1'b1) begin failures++; $display("FAIL basic_beat0_accept got=%0b expected=1", acc); end
    in_data_i = 32'h2222_2222; in_last_i = 1'b1; tick(acc);
    checks++;
    if (acc !== 1'b1) begin failures++; $display("FAIL basic_beat1_accept got=%0b expected=1", acc); end
    in_valid_i = 1'b0; in_last_i = 1'b0;
    checks++;
    if ({WriteEnable_o, WriteAddr_o, WriteData_o} !== {1'b1, 5'd3, 64'h2222_2222_1111_1111}) begin
      failures++;
      $display("FAIL basic_write we=%0b addr=%0d data=%h expected we=1 addr=3 data=2222222211111111",
               WriteEnable_o, WriteAddr_o, WriteData_o);
    end
    repeat (5) tick(acc);
    checks++;
    if (word_cnt_o !== 6'd1) begin failures++; $display("FAIL basic_cnt got=%0d expected=1", word_cnt_o); end
    checks++;
    if (done_cnt !== 1) begin failures++; $display("FAIL basic_done pulses=%0d expected=1", done_cnt); end
    checks++;
    if (got_q.size() != 1) begin
      failures++; $display("FAIL basic_commits got=%0d expected=1", got_q.size());
    end else if (got_q[0] !== {5'd3, 64'h2222_2222_1111_1111}) begin
      failures++; $display("FAIL basic_row got=%h expected=%h", got_q[0], {5'd3, 64'h2222_2222_1111_1111});
    end
  endtask

  task automatic test_stall();
    bit acc;
    logic [68:0] snap;
    beats_q = '{32'hA0A0_0001, 32'hB0B0_0002, 32'hC0C0_0003};
    got_q.delete(); done_cnt = 0;
    start_i = 1'b1; base_addr_i = 5'd0; tick(acc); start_i = 1'b0;
    in_valid_i = 1'b1; in_last_i = 1'b0;
    in_data_i = beats_q[0]; tick(acc);
    in_data_i = beats_q[1]; tick(acc);
    wr_stall_i = 1'b1; in_data_i = beats_q[2]; in_last_i = 1'b1;
    snap = {WriteAddr_o, WriteData_o};
    checks++;
    if (WriteEnable_o !== 1'b1) begin failures++; $display("FAIL stall_we_start got=%0b expected=1", WriteEnable_o); end
    for (int i = 0; i < 4; i++) begin
      tick(acc);
      checks++;
      if ({WriteEnable_o, WriteAddr_o, WriteData_o} !== {1'b1, snap}) begin
        failures++;
        $display("FAIL stall_hold cyc=%0d we=%0b addr/data=%h expected we=1 addr/data=%h",
                 i, WriteEnable_o, {WriteAddr_o, WriteData_o}, snap);
      end
      checks++;
      if (in_ready_o !== 1'b0 || acc !== 1'b0) begin
        failures++; $display("FAIL stall_ready cyc=%0d rdy=%0b expected=0", i, in_ready_o);
      end
    end
    wr_stall_i = 1'b0;
    tick(acc);
    checks++;
    if (acc !== 1'b1) begin failures++; $display("FAIL stall_release_accept got=%0b expected=1", acc); end
    in_valid_i = 1'b0; in_last_i = 1'b0;
    repeat (8) tick(acc);
    model_packet(0, 3);
    checks++;
    if (got_q.size() != exp_q.size()) begin
      failures++; $display("FAIL stall_commits got=%0d expected=%0d", got_q.size(), exp_q.size());
    end else begin
      foreach (exp_q[i]) begin
        checks++;
        if (got_q[i] !== exp_q[i]) begin
          failures++; $display("FAIL stall_row%0d got=%h expected=%h", i, got_q[i], exp_q[i]);
        end
      end
    end
    checks++;
    if (int'(word_cnt_o) !== exp_q.size()) begin
      failures++; $display("FAIL stall_cnt got=%0d expected=%0d", word_cnt_o, exp_q.size());
    end
    checks++;
    if (done_cnt !== 1) begin failures++; $display("FAIL stall_done pulses=%0d expected=1", done_cnt); end
  endtask

  task automatic test_random_packets(input int npkt, input int min_len, input int max_len);
    int base;
    int n;
    for (int p = 0; p < npkt; p++) begin
      n = int'($urandom_range(max_len - min_len)) + min_len;
      base = int'($urandom_range(NR - 1));
      beats_q.delete();
      for (int i = 0; i < n; i++) beats_q.push_back($urandom);
      run_packet(base, 30, 30);
      checks++;
      if (got_q.size() != exp_q.size()) begin
        failures++;
        $display("FAIL pkt%0d_commits len=%0d got=%0d expected=%0d", p, n, got_q.size(), exp_q.size());
      end else begin
        foreach (exp_q[i]) begin
          checks++;
          if (got_q[i] !== exp_q[i]) begin
            failures++; $display("FAIL pkt%0d_row%0d got=%h expected=%h", p, i, got_q[i], exp_q[i]);
          end
        end
      end
      checks++;
      if (int'(word_cnt_o) !== exp_q.size() || full_o !== 1'b0) begin
        failures++;
        $display("FAIL pkt%0d_cnt cnt=%0d full=%0b expected cnt=%0d full=0", p, word_cnt_o, full_o, exp_q.size());
      end
      checks++;
      if (done_cnt !== 1) begin failures++; $display("FAIL pkt%0d_done pulses=%0d expected=1", p, done_cnt); end
    end
  endtask

  task automatic test_back_to_back_wrap_full();
    bit acc;
    beats_q.delete();
    for (int i = 0; i < 2*NR; i++) beats_q.push_back($urandom);
    run_packet(30, 0, 0);
    checks++;
    if (beat_ticks !== 2*NR) begin
      failures++; $display("FAIL b2b_throughput cycles=%0d expected=%0d", beat_ticks, 2*NR);
    end
    checks++;
    if (got_q.size() != exp_q.size()) begin
      failures++; $display("FAIL wrap_commits got=%0d expected=%0d", got_q.size(), exp_q.size());
    end else begin
      foreach (exp_q[i]) begin
        checks++;
        if (got_q[i] !== exp_q[i]) begin
          failures++; $display("FAIL wrap_row%0d got=%h expected=%h", i, got_q[i], exp_q[i]);
        end
      end
    end
    checks++;
    if (full_o !== 1'b1 || word_cnt_o !== 6'(NR)) begin
      failures++; $display("FAIL full_state full=%0b cnt=%0d expected full=1 cnt=%0d", full_o, word_cnt_o, NR);
    end
    checks++;
    if (done_cnt !== 1) begin failures++; $display("FAIL full_done pulses=%0d expected=1", done_cnt); end
    in_valid_i = 1'b1; in_data_i = 32'h5555_aaaa; in_last_i = 1'b0;
    repeat (5) begin
      tick(acc);
      checks++;
      if (in_ready_o !== 1'b0) begin failures++; $display("FAIL full_ready rdy=%0b expected=0", in_ready_o); end
    end
    in_valid_i = 1'b0;
  endtask

  task automatic test_restart();
    bit acc;
    got_q.delete(); done_cnt = 0;
    start_i = 1'b1; base_addr_i = 5'd5; tick(acc); start_i = 1'b0;
    in_valid_i = 1'b1; in_last_i = 1'b0;
    in_data_i = 32'h0000_00a1; tick(acc);
    in_data_i = 32'h0000_00b2; tick(acc);
    in_valid_i = 1'b0; wr_stall_i = 1'b1; tick(acc);
    start_i = 1'b1; base_addr_i = 5'd7; in_valid_i = 1'b1; in_data_i = 32'hffff_0000;
    tick(acc);
    checks++;
    if (acc !== 1'b0) begin failures++; $display("FAIL restart_beat_taken got=%0b expected=0", acc); end
    start_i = 1'b0; wr_stall_i = 1'b0; in_valid_i = 1'b0;
    checks++;
    if (WriteEnable_o !== 1'b0 || word_cnt_o !== 6'd0) begin
      failures++; $display("FAIL restart_clear we=%0b cnt=%0d expected we=0 cnt=0", WriteEnable_o, word_cnt_o);
    end
    in_valid_i = 1'b1;
    in_data_i = 32'h0000_00c3; tick(acc);
    in_data_i = 32'h0000_00d4; in_last_i = 1'b1; tick(acc);
    in_valid_i = 1'b0; in_last_i = 1'b0;
    repeat (5) tick(acc);
    checks++;
    if (got_q.size() != 1) begin
      failures++; $display("FAIL restart_commits got=%0d expected=1", got_q.size());
    end else if (got_q[0] !== {5'd7, 32'h0000_00d4, 32'h0000_00c3}) begin
      failures++; $display("FAIL restart_row got=%h expected=%h", got_q[0], {5'd7, 32'h0000_00d4, 32'h0000_00c3});
    end
    checks++;
    if (word_cnt_o !== 6'd1 || done_cnt !== 1) begin
      failures++; $display("FAIL restart_cnt cnt=%0d done=%0d expected cnt=1 done=1", word_cnt_o, done_cnt);
    end

    // Restart while holding a low half: the competing beat is refused and
    // the held half is dropped.
    got_q.delete(); done_cnt = 0;
    start_i = 1'b1; base_addr_i = 5'd9; tick(acc); start_i = 1'b0;
    in_valid_i = 1'b1; in_data_i = 32'h1234_0001; tick(acc);
    start_i = 1'b1; base_addr_i = 5'd12; in_data_i = 32'h1234_0002; tick(acc);
    checks++;
    if (acc !== 1'b0) begin failures++; $display("FAIL restart_priority got=%0b expected=0", acc); end
    start_i = 1'b0;
    in_data_i = 32'h1234_00e5; tick(acc);
    in_data_i = 32'h1234_00f6; in_last_i = 1'b1; tick(acc);
    in_valid_i = 1'b0; in_last_i = 1'b0;
    repeat (5) tick(acc);
    checks++;
    if (got_q.size() != 1) begin
      failures++; $display("FAIL restart2_commits got=%0d expected=1", got_q.size());
    end else if (got_q[0] !== {5'd12, 32'h1234_00f6, 32'h1234_00e5}) begin
      failures++; $display("FAIL restart2_row got=%h expected=%h", got_q[0], {5'd12, 32'h1234_00f6, 32'h1234_00e5});
    end
  endtask

  task automatic test_reset_midpacket();
    bit acc;
    got_q.delete(); done_cnt = 0;
    start_i = 1'b1; base_addr_i = 5'd2; tick(acc); start_i = 1'b0;
    in_valid_i = 1'b1; in_last_i = 1'b0;
    in_data_i = 32'h7777_0001; tick(acc);
    in_data_i = 32'h7777_0002; tick(acc);
    in_valid_i = 1'b0; tick(acc);
    in_valid_i = 1'b1; in_data_i = 32'h7777_0003; tick(acc);
    in_valid_i = 1'b0;
    #3;
    rst_n = 1'b0;
    #1;
    checks++;
    if ({WriteEnable_o, WriteAddr_o, WriteData_o, word_cnt_o, full_o, done_o, in_ready_o} !== '0) begin
      failures++;
      $display("FAIL async_reset_outputs we=%0b addr=%0d data=%h cnt=%0d full=%0b done=%0b rdy=%0b expected all 0",
               WriteEnable_o, WriteAddr_o, WriteData_o, word_cnt_o, full_o, done_o, in_ready_o);
    end
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    got_q.delete();
    in_valid_i = 1'b1; in_data_i = 32'h8888_0000;
    repeat (10) begin
      tick(acc);
      checks++;
      if (acc !== 1'b0) begin failures++; $display("FAIL post_reset_accept got=%0b expected=0", acc); end
    end
    in_valid_i = 1'b0;
    checks++;
    if (got_q.size() != 0) begin
      failures++; $display("FAIL post_reset_writes got=%0d expected=0", got_q.size());
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL global_timeout");
    $fatal(1, "timeout");
  end

  initial begin
    repeat (3) @(negedge clk);
    test_reset();
    test_basic_pairing();
    test_stall();
    test_random_packets(4, 3, 3);
    test_random_packets(25, 1, 12);
    test_back_to_back_wrap_full();
    test_restart();
    test_reset_midpacket();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
